spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 190 +++++++++++++++++++
 tb/tb_spi_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: serialises one DATAWIDTH_BUS-bit frame MSB first while shifting in MISO.
// Latency: newData is a registered pulse (2*DATAWIDTH_BUS+2)*CLK_DIV edges after the START edge.
// Backpressure: START is honoured only in IDLE; requests arriving while busy are dropped, not queued.
//
// Ports:
//   SPI_MASTER_CLOCK_50      system clock, every register on its rising edge
//   SPI_MASTER_RESET_InHigh  synchronous active-high reset, wins over START
//   SPI_MASTER_START_InHigh  transaction request, sampled in IDLE only
//   SPI_MASTER_data_In       frame to send, captured on START acceptance
//   SPI_MASTER_MISO_In       serial data from the slave
//   SPI_MASTER_SCK_Out       SPI clock, idle low
//   SPI_MASTER_SS_OutLow     slave select, active low
//   SPI_MASTER_MOSI_Out      serial data to the slave, MSB first, 0 when idle
//   SPI_MASTER_data_Out      last complete received frame, held between transactions
//   SPI_MASTER_newData_Out   one-cycle pulse when data_Out is reloaded
//   SPI_MASTER_busy_Out      high from START acceptance until back in IDLE
module spi_master #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 3,
    parameter int CLK_DIV       = 4
) (
    input  logic                     SPI_MASTER_CLOCK_50,
    input  logic                     SPI_MASTER_RESET_InHigh,
    input  logic                     SPI_MASTER_START_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_In,
    input  logic                     SPI_MASTER_MISO_In,
    output logic                     SPI_MASTER_SCK_Out,
    output logic                     SPI_MASTER_SS_OutLow,
    output logic                     SPI_MASTER_MOSI_Out,
    output logic [DATAWIDTH_BUS-1:0] SPI_MASTER_data_Out,
    output logic                     SPI_MASTER_newData_Out,
    output logic                     SPI_MASTER_busy_Out
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATAWIDTH_BUS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATAWIDTH_BUS);

    typedef enum logic [STATE_SIZE-1:0] {
        IDLE     = STATE_SIZE'(0),
        SETUP    = STATE_SIZE'(1),
        SCK_HIGH = STATE_SIZE'(2),
        SCK_LOW  = STATE_SIZE'(3),
        HOLD     = STATE_SIZE'(4),
        DONE     = STATE_SIZE'(5)
    } state_t;

    state_t                   state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [DATAWIDTH_BUS-1:0] tx_q, tx_d;
    logic [DATAWIDTH_BUS-1:0] rx_q, rx_d;
    logic [DATAWIDTH_BUS-1:0] dout_q, dout_d;
    logic                     sck_q, sck_d;
    logic                     ss_q, ss_d;
    logic                     mosi_q, mosi_d;
    logic                     nd_q, nd_d;
    logic                     busy_q, busy_d;

    logic                     div_last;
    logic [BIT_W-1:0]         bit_inc;
    logic [DATAWIDTH_BUS-1:0] rx_shift;
    logic [DATAWIDTH_BUS-1:0] tx_shift;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sck_d   = sck_q;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        nd_d    = 1'b0;
        busy_d  = busy_q;

        div_last = (div_q == DIV_LAST);
        bit_inc  = bit_q + 1'b1;
        // First received bit travels up to the MSB after a full frame of left shifts.
        rx_shift = (rx_q << 1) | DATAWIDTH_BUS'(SPI_MASTER_MISO_In);
        // MOSI always shows tx_q's MSB, so advancing a bit is a left shift.
        tx_shift = tx_q << 1;

        // Every timed state counts CLK_DIV cycles and rolls the divider over on exit.
        if (state_q != IDLE && state_q != DONE) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (SPI_MASTER_START_InHigh) begin
                    tx_d    = SPI_MASTER_data_In;
                    rx_d    = '0;
                    bit_d   = '0;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = SPI_MASTER_data_In[DATAWIDTH_BUS-1];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    sck_d   = 1'b1;
                    rx_d    = rx_shift;
                    state_d = SCK_HIGH;
                end
            end
            SCK_HIGH: begin
                if (div_last) begin
                    sck_d   = 1'b0;
                    bit_d   = bit_inc;
                    state_d = SCK_LOW;
                    // After the final bit MOSI keeps the LSB through HOLD.
                    if (bit_inc < BIT_LAST) begin
                        tx_d   = tx_shift;
                        mosi_d = tx_shift[DATAWIDTH_BUS-1];
                    end
                end
            end
            SCK_LOW: begin
                if (div_last) begin
                    if (bit_q < BIT_LAST) begin
                        sck_d   = 1'b1;
                        rx_d    = rx_shift;
                        state_d = SCK_HIGH;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    ss_d    = 1'b1;
                    dout_d  = rx_q;
                    nd_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // DONE plus one IDLE cycle guarantee two SS-high cycles even with START held.
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
                div_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge SPI_MASTER_CLOCK_50) begin
        if (SPI_MASTER_RESET_InHigh) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            nd_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sck_q   <= sck_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            nd_q    <= nd_d;
            busy_q  <= busy_d;
        end
    end

    assign SPI_MASTER_SCK_Out     = sck_q;
    assign SPI_MASTER_SS_OutLow   = ss_q;
    assign SPI_MASTER_MOSI_Out    = mosi_q;
    assign SPI_MASTER_data_Out    = dout_q;
    assign SPI_MASTER_newData_Out = nd_q;
    assign SPI_MASTER_busy_Out    = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: directed corner cases plus randomized frames against a slave model.
// Latency: expectations are timestamped in cycles relative to the cycle START is driven.
// Backpressure: the driver only requests while its own model says the master is idle,
// apart from deliberate spurious START pulses that must be ignored.
module tb_spi_master;

    localparam int N     = 8;
    localparam int DIV   = 4;
    // Cycle count from driving START to seeing newData; the cycle right after the
    // accepting edge counts as 1, so SS is low for LAT-1 cycles.
    localparam int LAT   = (2 * N + 2) * DIV + 1;
    // With START held, DONE and one IDLE cycle separate the frames.
    localparam int B2B   = LAT + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] data_in;
    logic         miso;
    logic         sck;
    logic         ss_n;
    logic         mosi;
    logic [N-1:0] data_out;
    logic         new_data;
    logic         busy;

    logic [N-1:0] slave_byte;
    logic [N-1:0] slave_sr;
    logic         loopback;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [N-1:0] rx;
        logic [N-1:0] tx;
        int           nd_cyc;
        int           gap;
    } exp_t;

    exp_t sb[$];

    spi_master #(.DATAWIDTH_BUS(N), .STATE_SIZE(3), .CLK_DIV(DIV)) dut (
        .SPI_MASTER_CLOCK_50     (clk),
        .SPI_MASTER_RESET_InHigh (rst),
        .SPI_MASTER_START_InHigh (start),
        .SPI_MASTER_data_In      (data_in),
        .SPI_MASTER_MISO_In      (miso),
        .SPI_MASTER_SCK_Out      (sck),
        .SPI_MASTER_SS_OutLow    (ss_n),
        .SPI_MASTER_MOSI_Out     (mosi),
        .SPI_MASTER_data_Out     (data_out),
        .SPI_MASTER_newData_Out  (new_data),
        .SPI_MASTER_busy_Out     (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Mode-0 slave: presents its MSB while SS is low and advances on each SCK fall.
    assign miso = loopback ? mosi : slave_sr[N-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: per-cycle invariants, per-frame capture, scoreboard pop on newData.
    initial begin
        logic         prev_ss, prev_sck, prev_nd;
        logic [N-1:0] mosi_cap;
        int           rises, ss_low, ss_rise_cyc;
        exp_t         e;
        prev_ss = 1'b1; prev_sck = 1'b0; prev_nd = 1'b0;
        mosi_cap = '0; rises = 0; ss_low = 0; ss_rise_cyc = 0;
        slave_sr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!busy) begin
                    check("idle_ss", 32'(ss_n), 32'd1);
                    check("idle_sck", 32'(sck), 32'd0);
                    check("idle_mosi", 32'(mosi), 32'd0);
                end
                if (!ss_n) check("busy_while_selected", 32'(busy), 32'd1);
                if (ss_n && !prev_ss) ss_rise_cyc = cyc;
                if (!ss_n && prev_ss) begin
                    mosi_cap = '0; rises = 0; ss_low = 0;
                    slave_sr = slave_byte;
                    if (sb.size() > 0 && sb[0].gap != 0)
                        check("ss_gap", 32'(cyc - ss_rise_cyc), 32'(sb[0].gap));
                end
                if (!ss_n) ss_low++;
                if (sck && !prev_sck) begin
                    rises++;
                    mosi_cap = {mosi_cap[N-2:0], mosi};
                end
                if (!sck && prev_sck) slave_sr = slave_sr << 1;
                if (prev_nd) check("nd_single_cycle", 32'(new_data), 32'd0);
                if (new_data && !prev_nd) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_newdata: got pulse expected none at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("data_out", 32'(data_out), 32'(e.rx));
                        check("nd_cycle", 32'(cyc), 32'(e.nd_cyc));
                        check("mosi_bits", 32'(mosi_cap), 32'(e.tx));
                        check("sck_rises", 32'(rises), 32'(N));
                        check("ss_low_cycles", 32'(ss_low), 32'(LAT - 1));
                    end
                end
                prev_ss  = ss_n;
                prev_sck = sck;
                prev_nd  = new_data;
            end
        end
    end

    // One frame; spur != 0 adds an ignored START pulse (with junk data) at that offset.
    task automatic txn(input logic [N-1:0] tx, input logic [N-1:0] sl, input bit lb,
                       input int spur, input int gap);
        int   c;
        exp_t e;
        @(negedge clk);
        c = cyc;
        data_in = tx; slave_byte = sl; loopback = lb; start = 1'b1;
        e.rx = lb ? tx : sl; e.tx = tx; e.nd_cyc = c + LAT; e.gap = 0;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        data_in = N'($urandom);
        while (cyc < c + LAT) begin
            @(negedge clk);
            if (spur != 0 && cyc == c + spur) begin
                start = 1'b1;
                data_in = N'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        repeat (gap) @(negedge clk);
    endtask

    // START held high across two frames.
    task automatic back_to_back(input logic [N-1:0] tx, input logic [N-1:0] sl);
        int   c;
        exp_t e;
        @(negedge clk);
        c = cyc;
        data_in = tx; slave_byte = sl; loopback = 1'b0; start = 1'b1;
        e.rx = sl; e.tx = tx; e.nd_cyc = c + LAT; e.gap = 0;
        sb.push_back(e);
        e.nd_cyc = c + B2B + LAT; e.gap = 2;
        sb.push_back(e);
        while (cyc < c + B2B + LAT) begin
            @(negedge clk);
            if (cyc > c + B2B) start = 1'b0;
        end
    endtask

    // Reset 30 cycles into a frame, with START also high to show reset wins.
    task automatic abort_frame();
        int c;
        @(negedge clk);
        c = cyc;
        data_in = 8'hFF; slave_byte = 8'hFF; loopback = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 30) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("abort_ss", 32'(ss_n), 32'd1);
        check("abort_sck", 32'(sck), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_nd", 32'(new_data), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("reset_beats_start", 32'(busy), 32'd0);
        repeat (90) @(negedge clk);
        check("abort_data_out_held", 32'(data_out), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; data_in = '0;
        slave_byte = '0; loopback = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_ss", 32'(ss_n), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_nd", 32'(new_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        txn(8'hA5, 8'h00, 1'b1, 0, 0);
        txn(8'h00, 8'hFF, 1'b0, 0, 1);
        txn(8'h80, 8'h5A, 1'b0, 20, 2);
        abort_frame();
        back_to_back(8'h3C, 8'hC3);
        for (int i = 0; i < 12; i++) begin
            txn(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 70)) : 0,
                int'($urandom_range(0, 4)));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
